// File: rtl/tdc_fifo_write_arbiter.sv
// Round-robin arbiter sharing one event-FIFO write port between N_REQ TDC channels.
// Each grant issues one write strobe, waits for the writer's acknowledge (or a timeout), then pulses done.
module tdc_fifo_write_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          done,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [ID_W+DATA_W-1:0]    fifo_din,
    input  logic                      f_FIFO_writing_done,
    output logic                      timeout_err,
    output logic                      busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     gnt;
    logic [CNT_W-1:0]    wait_cnt;

    logic                sel_vld;
    logic [ID_W-1:0]     sel_id;
    logic [DATA_W-1:0]   sel_data;
    int                  idx;

    logic                grant;
    logic                ack_seen;
    logic                to_hit;
    logic                finish;

    logic [N_REQ-1:0]    done_nxt;
    logic                wr_en_nxt;
    logic                terr_nxt;
    logic                busy_nxt;

    // Scan requests starting at rr_ptr, wrapping modulo N_REQ; first hit wins.
    always_comb begin
        sel_vld  = 1'b0;
        sel_id   = '0;
        sel_data = '0;
        idx      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!sel_vld && req[idx]) begin
                sel_vld  = 1'b1;
                sel_id   = ID_W'(idx);
                sel_data = req_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign grant    = (state == IDLE) && sel_vld && !fifo_full;
    assign ack_seen = (state == WAIT_DONE) && f_FIFO_writing_done;
    assign to_hit   = (state == WAIT_DONE) && (wait_cnt == TIMEOUT_C);
    assign finish   = ack_seen || to_hit;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            done        <= '0;
            fifo_wr_en  <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            done        <= done_nxt;
            fifo_wr_en  <= wr_en_nxt;
            timeout_err <= terr_nxt;
            busy        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant) state_nxt = WRITE;
            WRITE:     state_nxt = WAIT_DONE;
            WAIT_DONE: if (finish) state_nxt = RELEASE;
            RELEASE:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Acknowledge beats timeout when both land on the same cycle.
    always_comb begin
        wr_en_nxt = grant;
        done_nxt  = finish ? (N_REQ'(1) << gnt) : '0;
        terr_nxt  = to_hit && !ack_seen;
        busy_nxt  = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr   <= '0;
            wait_cnt <= '0;
            fifo_din <= '0;
        end else begin
            if (grant) fifo_din <= {sel_id, sel_data};
            if (state == WRITE) begin
                wait_cnt <= '0;
            end else if ((state == WAIT_DONE) && !finish) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (finish) rr_ptr <= (gnt == LAST_ID) ? '0 : gnt + 1'b1;
        end
    end

    // Granted id is only consumed while a write is in flight, so it needs no reset.
    always_ff @(posedge clk) begin
        if (grant) gnt <= sel_id;
    end

endmodule
